clip_sequencer: RTL and testbench
=================================

Name: clip_sequencer

Overview:
- Parametrised successor of the two-clip record/playback controller.
- Supports NUM_CLIPS clip slots with per-clip address counting and recorded-length tracking.
- Has a sample-tick-paced memory access handshake and a timed error state.
- Sits between user buttons/switches, the audio (de)serializers and the clip memories.

Parameters:
NUM_CLIPS, 2, number of clip memories (1..16)
ADDR_WIDTH, 16, address width per clip memory; depth = 2**ADDR_WIDTH samples
ERROR_CYCLES, 100000000, cycles ERROR is held before returning to IDLE (1 s at 100 MHz)

Ports:
clock_i  in  1  100 MHz clock
reset_i  in  1  asynchronous, active-low reset
clip_select_i  in  $clog2(NUM_CLIPS) (min 1)  clip index, async switches
play_i  in  1  play/stop button, async
record_i  in  1  record/stop button, async
sample_tick_i  in  1  one-cycle strobe at audio sample rate
serializer_enable_o  out  1  playback path enable
deserializer_enable_o  out  1  capture path enable
memory_enable_o  out  NUM_CLIPS  one-hot access strobe
memory_rw_o  out  1  1 = write, 0 = read
memory_addr_o  out  ADDR_WIDTH  sample address
clip_valid_o  out  NUM_CLIPS  clip holds a recording
busy_o  out  1  RECORDING or PLAYING
error_o  out  1  high in ERROR

Behaviour:
- Reset (reset_i low, async): state RESET. All outputs are 0. Lengths, clip_valid and counters are cleared. RESET goes to IDLE on the first clock after release.
- Conditioning: play_i, record_i and clip_select_i each pass through a 2-flop synchronizer. Buttons then get rising-edge detection, giving play_pulse and record_pulse. A pulse is valid 3 clocks after the input edge. The state changes on the following edge.
- clip_select is latched into cur_clip only when a command is accepted in IDLE. Switch changes mid-operation are ignored.
- IDLE:
  - record_pulse with sel < NUM_CLIPS -> RECORDING; addr = 0.
  - play_pulse with sel valid and clip_valid[sel] -> PLAYING; addr = 0.
  - sel >= NUM_CLIPS, or play of an unrecorded clip -> ERROR.
  - Simultaneous record_pulse and play_pulse: record wins.
- RECORDING:
  - deserializer_enable_o = 1 and memory_rw_o = 1.
  - On sample_tick_i: memory_enable_o[cur_clip] = 1 for that cycle, memory_addr_o = addr, and addr increments next cycle.
  - Stop on record_pulse: length[cur_clip] = addr, clip_valid = (addr != 0), state -> IDLE.
  - Full: the tick that writes addr 2**ADDR_WIDTH-1 sets length = 2**ADDR_WIDTH (ADDR_WIDTH+1 bits), sets clip_valid and goes to IDLE.
  - play_pulse is ignored.
  - A record_pulse coinciding with a tick: the write completes first, then the stop is applied.
- PLAYING:
  - serializer_enable_o = 1 and memory_rw_o = 0.
  - On sample_tick_i: memory_enable_o[cur_clip] pulses at addr, and addr increments.
  - The tick reading addr = length-1 ends playback -> IDLE.
  - play_pulse stops playback immediately. record_pulse is ignored.
- ERROR: error_o = 1, all enables 0. Counts ERROR_CYCLES clocks, then -> IDLE. Pulses are ignored.
- Strobe rule: memory_enable_o is never asserted outside a sample_tick_i cycle and is at most one-hot.
- Recording over an existing clip clears its clip_valid at entry to RECORDING.

Optional Feature:
- Macro: CLIP_SEQUENCER_LOOP_EN.
- Defined: at the end of a clip, PLAYING wraps addr to 0 and continues until play_pulse.
- Undefined: the end of a clip returns to IDLE as described above.

Decomposition:
- Package clip_sequencer_pkg holds:
  - the state enum (RESET, IDLE, RECORDING, PLAYING, ERROR)
  - a localparam for the memory_rw encoding
  - a function for clip-select width
- Sub-module button_conditioner: 2-flop synchronizer plus rising-edge pulse. It is instantiated once per button. The switch uses the synchronizer only.

Test Plan:
- NUM_CLIPS=4, ADDR_WIDTH=4. Reset mid-RECORDING at addr 5 -> all outputs 0, clip_valid=0000, state IDLE one clock after release.
- sel=2, record press, 6 ticks, record press -> 6 writes at addr 0..5 on memory_enable_o=0100 with rw=1; length[2]=6; clip_valid=0100.
- Play sel=2 -> 6 reads at addr 0..5, then IDLE. With LOOP_EN, the 7th tick reads addr 0.
- Record sel=1 with 16 ticks -> the write at addr 15 auto-stops; length[1]=16; busy_o falls the next cycle.
- Play sel=3 (unrecorded) -> error_o high for exactly ERROR_CYCLES (set to 10), then IDLE. Pulses during ERROR are ignored.
- Record and play pressed in the same cycle in IDLE -> RECORDING. A play press during RECORDING has no effect. A stop-record coincident with a tick performs that write.

Source files
------------

// File: rtl/clip_sequencer_pkg.sv
// Shared types and helpers for the clip record/playback sequencer.
package clip_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_RECORDING,
        ST_PLAYING,
        ST_ERROR
    } state_e;

    // memory_rw_o encoding
    localparam logic MEM_RW_WRITE = 1'b1;
    localparam logic MEM_RW_READ  = 1'b0;

    // Clip-select width; a single clip still needs a 1-bit select port.
    function automatic int clip_sel_width(input int num_clips);
        return (num_clips > 1) ? $clog2(num_clips) : 1;
    endfunction

endpackage

// File: rtl/clip_sequencer_button_conditioner.sv
// Button conditioner: 2-flop synchronizer followed by a registered
// rising-edge detector. The pulse is high for one clock, three clocks
// after the asynchronous input rises.
module button_conditioner (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_s1, r_s2, r_prev, r_pulse;

    // Synchronize the button, then register a one-cycle rising-edge pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_s1    <= i_btn;
            r_s2    <= r_s1;
            r_prev  <= r_s2;
            r_pulse <= r_s2 & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/clip_sequencer.sv
// Clip record/playback sequencer for NUM_CLIPS clip memories.
// Records samples into the selected clip on each sample tick, tracks each
// clip's recorded length, and plays clips back at the same tick rate.
// Optional build macro CLIP_SEQUENCER_LOOP_EN: playback wraps to address 0
// at the end of a clip and keeps going until play is pressed again.
module clip_sequencer
    import clip_sequencer_pkg::*;
#(
    parameter int NUM_CLIPS    = 2,
    parameter int ADDR_WIDTH   = 16,
    parameter int ERROR_CYCLES = 100000000
) (
    input  logic                                 clock_i,
    input  logic                                 reset_i,
    input  logic [clip_sel_width(NUM_CLIPS)-1:0] clip_select_i,
    input  logic                                 play_i,
    input  logic                                 record_i,
    input  logic                                 sample_tick_i,
    output logic                                 serializer_enable_o,
    output logic                                 deserializer_enable_o,
    output logic [NUM_CLIPS-1:0]                 memory_enable_o,
    output logic                                 memory_rw_o,
    output logic [ADDR_WIDTH-1:0]                memory_addr_o,
    output logic [NUM_CLIPS-1:0]                 clip_valid_o,
    output logic                                 busy_o,
    output logic                                 error_o
);

    localparam int CW  = clip_sel_width(NUM_CLIPS);
    localparam int ECW = (ERROR_CYCLES > 1) ? $clog2(ERROR_CYCLES) : 1;
    localparam logic [ECW-1:0]      ERR_LAST = ECW'(ERROR_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] LEN_ONE  = (ADDR_WIDTH + 1)'(1);

    logic                  w_play_pulse, w_rec_pulse;
    logic [CW-1:0]         r_sel_s1, r_sel_s2;
    state_e                r_state, w_state_nxt;
    logic [CW-1:0]         r_cur_clip, w_cur_clip_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [ECW-1:0]        r_err_cnt, w_err_cnt_nxt;
    logic [ADDR_WIDTH:0]   r_len [NUM_CLIPS];
    logic [NUM_CLIPS-1:0]  r_valid;
    logic                  w_commit, w_clr_valid;
    logic [ADDR_WIDTH:0]   w_rec_len;
    logic                  w_sel_ok, w_sel_recorded, w_play_last, w_busy;

    button_conditioner u_play_btn (
        .i_clk   (clock_i),
        .i_rst_n (reset_i),
        .i_btn   (play_i),
        .o_pulse (w_play_pulse)
    );

    button_conditioner u_rec_btn (
        .i_clk   (clock_i),
        .i_rst_n (reset_i),
        .i_btn   (record_i),
        .o_pulse (w_rec_pulse)
    );

    // Clip-select switches need only synchronizing, no edge detection
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_sel_s1 <= '0;
            r_sel_s2 <= '0;
        end else begin
            r_sel_s1 <= clip_select_i;
            r_sel_s2 <= r_sel_s1;
        end
    end

    assign w_sel_ok       = 32'(r_sel_s2) < NUM_CLIPS;
    assign w_sel_recorded = w_sel_ok && r_valid[r_sel_s2];
    // A tick in the stop cycle still writes, so it counts toward the length
    assign w_rec_len      = {1'b0, r_addr} + {{ADDR_WIDTH{1'b0}}, sample_tick_i};
    assign w_play_last    = ({1'b0, r_addr} == (r_len[r_cur_clip] - LEN_ONE));

    // FSM state and datapath registers
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= ST_RESET;
            r_cur_clip <= '0;
            r_addr     <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_clip <= w_cur_clip_nxt;
            r_addr     <= w_addr_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
        end
    end

    // Next-state, address and error-timer logic
    always_comb begin
        w_state_nxt    = r_state;
        w_cur_clip_nxt = r_cur_clip;
        w_addr_nxt     = r_addr;
        w_err_cnt_nxt  = '0;
        w_commit       = 1'b0;
        w_clr_valid    = 1'b0;
        case (r_state)
            ST_RESET: w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                w_addr_nxt = '0;
                if (w_rec_pulse) begin
                    if (w_sel_ok) begin
                        w_state_nxt    = ST_RECORDING;
                        w_cur_clip_nxt = r_sel_s2;
                        w_clr_valid    = 1'b1;
                    end else begin
                        w_state_nxt = ST_ERROR;
                    end
                end else if (w_play_pulse) begin
                    if (w_sel_recorded) begin
                        w_state_nxt    = ST_PLAYING;
                        w_cur_clip_nxt = r_sel_s2;
                    end else begin
                        w_state_nxt = ST_ERROR;
                    end
                end
            end
            ST_RECORDING: begin
                if (sample_tick_i)
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                if (w_rec_pulse || (sample_tick_i && (&r_addr))) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PLAYING: begin
                if (sample_tick_i)
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                if (w_play_pulse) begin
                    w_state_nxt = ST_IDLE;
                end else if (sample_tick_i && w_play_last) begin
`ifdef CLIP_SEQUENCER_LOOP_EN
                    w_addr_nxt = '0;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
            ST_ERROR: begin
                w_err_cnt_nxt = r_err_cnt + ECW'(1);
                if (r_err_cnt == ERR_LAST)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-clip recorded length and valid flag
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < NUM_CLIPS; i++)
                r_len[i] <= '0;
            r_valid <= '0;
        end else begin
            if (w_clr_valid)
                r_valid[r_sel_s2] <= 1'b0;
            if (w_commit) begin
                r_len[r_cur_clip]   <= w_rec_len;
                r_valid[r_cur_clip] <= (w_rec_len != '0);
            end
        end
    end

    assign w_busy                = (r_state == ST_RECORDING) || (r_state == ST_PLAYING);
    assign busy_o                = w_busy;
    assign error_o               = (r_state == ST_ERROR);
    assign serializer_enable_o   = (r_state == ST_PLAYING);
    assign deserializer_enable_o = (r_state == ST_RECORDING);
    assign memory_rw_o           = (r_state == ST_RECORDING) ? MEM_RW_WRITE : MEM_RW_READ;
    assign memory_enable_o       = (w_busy && sample_tick_i) ? (NUM_CLIPS'(1) << r_cur_clip) : '0;
    assign memory_addr_o         = w_busy ? r_addr : '0;
    assign clip_valid_o          = r_valid;

endmodule

// File: tb/tb_clip_sequencer.sv
// Self-checking bench for clip_sequencer (4 clips, 16-sample clips,
// 10-cycle error hold) with a transaction-level model of clip contents.
module tb_clip_sequencer;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b0;
    logic [1:0] clip_select_i = '0;
    logic       play_i = 1'b0;
    logic       record_i = 1'b0;
    logic       sample_tick_i = 1'b0;
    logic       serializer_enable_o, deserializer_enable_o;
    logic [3:0] memory_enable_o;
    logic       memory_rw_o;
    logic [3:0] memory_addr_o;
    logic [3:0] clip_valid_o;
    logic       busy_o, error_o;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] model_valid = '0;
    int         model_len [4] = '{0, 0, 0, 0};

    clip_sequencer #(
        .NUM_CLIPS    (4),
        .ADDR_WIDTH   (4),
        .ERROR_CYCLES (10)
    ) dut (
        .clock_i               (clock_i),
        .reset_i               (reset_i),
        .clip_select_i         (clip_select_i),
        .play_i                (play_i),
        .record_i              (record_i),
        .sample_tick_i         (sample_tick_i),
        .serializer_enable_o   (serializer_enable_o),
        .deserializer_enable_o (deserializer_enable_o),
        .memory_enable_o       (memory_enable_o),
        .memory_rw_o           (memory_rw_o),
        .memory_addr_o         (memory_addr_o),
        .clip_valid_o          (clip_valid_o),
        .busy_o                (busy_o),
        .error_o               (error_o)
    );

    always #5 clock_i = ~clock_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock, drive the tick for the new cycle, let outputs settle
    task automatic cyc(input logic tk);
        @(posedge clock_i);
        #1;
        sample_tick_i = tk;
        #1;
    endtask

    // Button press; returns inside the cycle where the conditioned pulse is high
    task automatic press(input logic rec, input logic ply, input logic last_tick);
        record_i = rec;
        play_i   = ply;
        cyc(1'b0);
        cyc(1'b0);
        record_i = 1'b0;
        play_i   = 1'b0;
        cyc(last_tick);
    endtask

    task automatic tick_chk(input int sel, input int a, input logic rw);
        chk("strobe", 32'(memory_enable_o), 32'(1 << sel));
        chk("addr",   32'(memory_addr_o),   32'(a));
        chk("rw",     32'(memory_rw_o),     32'(rw));
    endtask

    task automatic gap_cycles();
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
            cyc(1'b0);
            chk("no_strobe_without_tick", 32'(memory_enable_o), 32'(0));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_en"},    32'(memory_enable_o),       32'(0));
        chk({tag, "_addr"},  32'(memory_addr_o),         32'(0));
        chk({tag, "_rw"},    32'(memory_rw_o),           32'(0));
        chk({tag, "_busy"},  32'(busy_o),                32'(0));
        chk({tag, "_err"},   32'(error_o),               32'(0));
        chk({tag, "_ser"},   32'(serializer_enable_o),   32'(0));
        chk({tag, "_deser"}, 32'(deserializer_enable_o), 32'(0));
        chk({tag, "_valid"}, 32'(clip_valid_o),          32'(0));
    endtask

    // Record n samples into clip sel; coinc stops with a tick in the stop cycle
    task automatic do_record(input int sel, input int n, input bit coinc);
        clip_select_i = 2'(sel);
        press(1'b1, 1'b0, 1'b0);
        cyc(1'b0);
        chk("rec_busy",  32'(busy_o),                32'(1));
        chk("rec_deser", 32'(deserializer_enable_o), 32'(1));
        chk("rec_rw",    32'(memory_rw_o),           32'(1));
        model_valid[sel] = 1'b0;
        chk("rec_valid_cleared", 32'(clip_valid_o), 32'(model_valid));
        for (int i = 0; i < n; i++) begin
            if (coinc && i == n - 1 && n < 16) begin
                press(1'b1, 1'b0, 1'b1);
            end else begin
                gap_cycles();
                cyc(1'b1);
            end
            tick_chk(sel, i, 1'b1);
        end
        if (n == 16 || (coinc && n > 0)) begin
            cyc(1'b0);
        end else begin
            press(1'b1, 1'b0, 1'b0);
            cyc(1'b0);
        end
        chk("rec_done_busy", 32'(busy_o), 32'(0));
        model_len[sel]   = n;
        model_valid[sel] = (n != 0);
        chk("rec_done_valid", 32'(clip_valid_o), 32'(model_valid));
    endtask

    // Play clip sel; an unrecorded clip must produce the timed error
    task automatic do_play(input int sel);
        int cnt;
        clip_select_i = 2'(sel);
        press(1'b0, 1'b1, 1'b0);
        cyc(1'b0);
        if (model_valid[sel]) begin
            chk("play_busy",  32'(busy_o),                32'(1));
            chk("play_ser",   32'(serializer_enable_o),   32'(1));
            chk("play_deser", 32'(deserializer_enable_o), 32'(0));
            for (int i = 0; i < model_len[sel]; i++) begin
                gap_cycles();
                cyc(1'b1);
                tick_chk(sel, i, 1'b0);
            end
`ifdef CLIP_SEQUENCER_LOOP_EN
            cyc(1'b1);
            tick_chk(sel, 0, 1'b0);
            press(1'b0, 1'b1, 1'b0);
            cyc(1'b0);
`else
            cyc(1'b0);
`endif
            chk("play_end_busy", 32'(busy_o), 32'(0));
        end else begin
            chk("err_flag", 32'(error_o), 32'(1));
            chk("err_busy", 32'(busy_o),  32'(0));
            cnt = 1;
            record_i = 1'b1;
            for (int k = 0; k < 40; k++) begin
                cyc((k % 2) == 1);
                if (k == 1) record_i = 1'b0;
                if (!error_o) break;
                cnt++;
                chk("err_strobe", 32'(memory_enable_o), 32'(0));
            end
            chk("err_cycles", 32'(cnt), 32'(10));
            cyc(1'b0);
            cyc(1'b0);
            chk("err_after_busy", 32'(busy_o),  32'(0));
            chk("err_after_flag", 32'(error_o), 32'(0));
        end
    endtask

    initial begin
        // Reset state
        repeat (3) cyc(1'b0);
        check_all_zero("reset");
        reset_i = 1'b1;

        // Reset in the middle of a recording at address 5
        clip_select_i = 2'd0;
        press(1'b1, 1'b0, 1'b0);
        cyc(1'b0);
        chk("pre_rst_busy", 32'(busy_o), 32'(1));
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1);
            tick_chk(0, i, 1'b1);
        end
        cyc(1'b0);
        chk("pre_rst_addr", 32'(memory_addr_o), 32'(5));
        reset_i = 1'b0;
        #1;
        check_all_zero("midrec_reset");
        cyc(1'b0);
        reset_i = 1'b1;
        cyc(1'b0);
        chk("post_rst_busy", 32'(busy_o),  32'(0));
        chk("post_rst_err",  32'(error_o), 32'(0));

        // Directed: record 6 into clip 2, play it back
        do_record(2, 6, 1'b0);
        chk("clip2_valid", 32'(clip_valid_o), 32'(4'b0100));
        do_play(2);

        // Directed: fill clip 1 to auto-stop
        do_record(1, 16, 1'b0);
        do_play(1);

        // Directed: play of an unrecorded clip
        do_play(3);

        // Simultaneous record+play in IDLE; play ignored while recording;
        // stop coincident with a tick keeps that write
        clip_select_i = 2'd0;
        press(1'b1, 1'b1, 1'b0);
        cyc(1'b0);
        chk("both_busy",  32'(busy_o),                32'(1));
        chk("both_deser", 32'(deserializer_enable_o), 32'(1));
        chk("both_ser",   32'(serializer_enable_o),   32'(0));
        model_valid[0] = 1'b0;
        press(1'b0, 1'b1, 1'b0);
        cyc(1'b0);
        chk("play_in_rec_deser", 32'(deserializer_enable_o), 32'(1));
        chk("play_in_rec_busy",  32'(busy_o),                32'(1));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1);
            tick_chk(0, i, 1'b1);
        end
        press(1'b1, 1'b0, 1'b1);
        tick_chk(0, 3, 1'b1);
        cyc(1'b0);
        chk("coinc_stop_busy", 32'(busy_o), 32'(0));
        model_len[0]   = 4;
        model_valid[0] = 1'b1;
        chk("coinc_valid", 32'(clip_valid_o), 32'(model_valid));
        do_play(0);

        // Randomized operations against the model
        for (int it = 0; it < 10; it++) begin
            int sel;
            sel = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1)
                do_record(sel, $urandom_range(0, 16), $urandom_range(0, 1) == 1);
            else
                do_play(sel);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
